// File: rtl/encoder_32to5_rr.sv
// encoder_32to5_rr
// Collects requests on 32 lines into a pending register and presents one
// pending line at a time as a registered 5-bit index with valid/ready.
// The index is removed from pending when the consumer accepts it.
// Arbitration is round-robin (RR_EN=1) or lowest-index-first (RR_EN=0).

module encoder_32to5_rr #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_i,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [4:0]  out_idx,
  output logic [31:0] pending_o
);

  // Architectural state: pending set, round-robin pointer, output stage.
  logic [31:0] pending_r;
  logic [4:0]  ptr_r;
  logic        valid_r;
  logic [4:0]  idx_r;

  // Per-cycle combinational terms.
  logic        acc_s;
  logic [31:0] clr_s;
  logic [31:0] cand_s;
  logic        load_s;
  logic [4:0]  start_s;
  logic [4:0]  probe_s;
  logic [4:0]  sel_s;
  logic        found_s;

  // Accept handshake, clear mask of the accepted index and candidate set.
  always_comb begin
    acc_s = valid_r & out_ready;
    if (acc_s) begin
      clr_s = 32'd1 << idx_r;
    end else begin
      clr_s = 32'd0;
    end
    cand_s = pending_r & ~clr_s;
    load_s = ~valid_r | acc_s;
  end

  // Search start: the pointer update and the reload share one edge, so on
  // an accept the scan already begins just past the index being retired.
  always_comb begin
    start_s = 5'd0;
    if (RR_EN != 0) begin
      if (acc_s) begin
        start_s = idx_r + 5'd1;
      end else begin
        start_s = ptr_r;
      end
    end else begin
      start_s = 5'd0;
    end
  end

  // Circular scan of the candidate set from start_s, first hit wins.
  always_comb begin
    sel_s   = 5'd0;
    found_s = 1'b0;
    probe_s = 5'd0;
    for (int i = 0; i < 32; i++) begin
      probe_s = start_s + 5'(i);
      if (!found_s && cand_s[probe_s]) begin
        found_s = 1'b1;
        sel_s   = probe_s;
      end else begin
        found_s = found_s;
        sel_s   = sel_s;
      end
    end
  end

  // Pending merge (set wins over clear), pointer advance and output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= 32'd0;
      ptr_r     <= 5'd0;
      valid_r   <= 1'b0;
      idx_r     <= 5'd0;
    end else begin
      pending_r <= cand_s | req_i;
      if (acc_s) begin
        ptr_r <= idx_r + 5'd1;
      end
      if (load_s) begin
        if (found_s) begin
          valid_r <= 1'b1;
          idx_r   <= sel_s;
        end else begin
          valid_r <= 1'b0;
        end
      end
    end
  end

  assign out_valid = valid_r;
  assign out_idx   = idx_r;
  assign pending_o = pending_r;

endmodule

// File: tb/tb_encoder_32to5_rr.sv
// Testbench for encoder_32to5_rr: a round-robin and a fixed-priority
// instance share stimulus; both are compared every cycle against a
// set-based reference model, with directed constant checks on top.

module tb_encoder_32to5_rr;

  logic        clk;
  logic        rst;
  logic [31:0] req_i;
  logic        out_ready;

  logic        rr_valid;
  logic [4:0]  rr_idx;
  logic [31:0] rr_pend;
  logic        fp_valid;
  logic [4:0]  fp_idx;
  logic [31:0] fp_pend;

  int checks = 0;
  int errors = 0;

  // Reference model state, slot 0 = round-robin, slot 1 = fixed priority.
  logic [31:0] m_pend  [2];
  logic [4:0]  m_ptr   [2];
  logic        m_valid [2];
  logic [4:0]  m_idx   [2];

  encoder_32to5_rr #(.RR_EN(1)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .out_ready (out_ready),
    .out_valid (rr_valid),
    .out_idx   (rr_idx),
    .pending_o (rr_pend)
  );

  encoder_32to5_rr #(.RR_EN(0)) u_fp (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .out_ready (out_ready),
    .out_valid (fp_valid),
    .out_idx   (fp_idx),
    .pending_o (fp_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Winner of a candidate set: smallest circular distance from start
  // (round-robin) or smallest index (fixed priority).
  function automatic logic [4:0] pick(input logic [31:0] c, input int start, input bit rr);
    int best;
    int best_d;
    int d;
    best   = 0;
    best_d = 64;
    for (int b = 0; b < 32; b++) begin
      if (c[b]) begin
        d = rr ? ((b - start + 32) % 32) : b;
        if (d < best_d) begin
          best_d = d;
          best   = b;
        end
      end
    end
    return 5'(best);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m]  = 32'd0;
      m_ptr[m]   = 5'd0;
      m_valid[m] = 1'b0;
      m_idx[m]   = 5'd0;
    end
  endtask

  task automatic model_edge(input logic [31:0] req, input logic rdy);
    logic        acc;
    logic [31:0] c;
    int          start;
    for (int m = 0; m < 2; m++) begin
      acc = m_valid[m] && rdy;
      c   = m_pend[m];
      if (acc) c[m_idx[m]] = 1'b0;
      start = acc ? ((int'(m_idx[m]) + 1) % 32) : int'(m_ptr[m]);
      if (acc) m_ptr[m] = 5'((int'(m_idx[m]) + 1) % 32);
      if (!m_valid[m] || acc) begin
        if (c != 32'd0) begin
          m_valid[m] = 1'b1;
          m_idx[m]   = pick(c, start, (m == 0));
        end else begin
          m_valid[m] = 1'b0;
        end
      end
      m_pend[m] = c | req;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, " rr valid"}, 32'(rr_valid), 32'(m_valid[0]));
    chk({tag, " rr idx"},   32'(rr_idx),   32'(m_idx[0]));
    chk({tag, " rr pend"},  rr_pend,       m_pend[0]);
    chk({tag, " fp valid"}, 32'(fp_valid), 32'(m_valid[1]));
    chk({tag, " fp idx"},   32'(fp_idx),   32'(m_idx[1]));
    chk({tag, " fp pend"},  fp_pend,       m_pend[1]);
  endtask

  // One clock: drive inputs, advance the model on the edge, sample #1 later.
  task automatic step(input string tag, input logic [31:0] req, input logic rdy);
    req_i     = req;
    out_ready = rdy;
    @(posedge clk);
    model_edge(req, rdy);
    #1;
    compare_all(tag);
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, " rr valid"}, 32'(rr_valid), 32'd0);
    chk({tag, " rr idx"},   32'(rr_idx),   32'd0);
    chk({tag, " rr pend"},  rr_pend,       32'd0);
    chk({tag, " fp valid"}, 32'(fp_valid), 32'd0);
    chk({tag, " fp pend"},  fp_pend,       32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    req_i     = 32'd0;
    out_ready = 1'b0;
    model_reset();
    #1;
    async_reset("reset");

    // Single request latency.
    step("single0", 32'h0000_0020, 1'b1);
    chk("single pend", rr_pend, 32'h20);
    chk("single nv", 32'(rr_valid), 32'd0);
    step("single1", 32'd0, 1'b1);
    chk("single valid", 32'(rr_valid), 32'd1);
    chk("single idx", 32'(rr_idx), 32'd5);
    step("single2", 32'd0, 1'b1);
    chk("single drop", 32'(rr_valid), 32'd0);
    chk("single empty", rr_pend, 32'd0);

    // Round-robin ordering and wrap.
    async_reset("reset2");
    step("rr0", 32'h8002_0008, 1'b1);
    step("rr1", 32'd0, 1'b1);
    chk("rr first", 32'(rr_idx), 32'd3);
    step("rr2", 32'd0, 1'b1);
    chk("rr second", 32'(rr_idx), 32'd17);
    step("rr3", 32'd0, 1'b1);
    chk("rr third", 32'(rr_idx), 32'd31);
    step("rr4", 32'd0, 1'b1);
    step("rrw0", 32'h8000_0008, 1'b1);
    step("rrw1", 32'd0, 1'b1);
    chk("rr wrap a", 32'(rr_idx), 32'd3);
    step("rrw2", 32'd0, 1'b1);
    chk("rr wrap b", 32'(rr_idx), 32'd31);
    step("rrw3", 32'd0, 1'b1);
    step("rrp0", 32'h0002_0000, 1'b1);
    step("rrp1", 32'd0, 1'b1);
    step("rrp2", 32'd0, 1'b1);
    step("rrp3", 32'h8000_0008, 1'b1);
    step("rrp4", 32'd0, 1'b1);
    chk("rr ptr18 a", 32'(rr_idx), 32'd31);
    chk("fp low a", 32'(fp_idx), 32'd3);
    step("rrp5", 32'd0, 1'b1);
    chk("rr ptr18 b", 32'(rr_idx), 32'd3);
    step("rrp6", 32'd0, 1'b1);

    // Backpressure: pointer sits at 4 here.
    step("bp0", 32'h0000_1010, 1'b0);
    step("bp1", 32'd0, 1'b0);
    chk("bp head", 32'(rr_idx), 32'd4);
    for (int k = 0; k < 5; k++) begin
      step("bphold", (k == 1) ? 32'h0000_0004 : 32'd0, 1'b0);
      chk("bp stable valid", 32'(rr_valid), 32'd1);
      chk("bp stable idx", 32'(rr_idx), 32'd4);
    end
    chk("bp pend", rr_pend, 32'h0000_1014);
    step("bp2", 32'd0, 1'b1);
    chk("bp next", 32'(rr_idx), 32'd12);
    step("bp3", 32'd0, 1'b1);
    chk("bp last", 32'(rr_idx), 32'd2);
    step("bp4", 32'd0, 1'b1);

    // Simultaneous set and clear on the accepted index.
    step("sc0", 32'h0010_0280, 1'b1);
    step("sc1", 32'd0, 1'b1);
    chk("sc head", 32'(rr_idx), 32'd7);
    step("sc2", 32'h0000_0080, 1'b1);
    chk("sc keep", rr_pend, 32'h0010_0280);
    chk("sc next", 32'(rr_idx), 32'd9);
    step("sc3", 32'd0, 1'b1);
    chk("sc third", 32'(rr_idx), 32'd20);
    step("sc4", 32'd0, 1'b1);
    chk("sc again", 32'(rr_idx), 32'd7);
    step("sc5", 32'd0, 1'b1);

    // Fixed priority with a held low request and a pulse on bit 9.
    async_reset("reset3");
    step("fp0", 32'h0000_0201, 1'b1);
    step("fp1", 32'h0000_0001, 1'b1);
    chk("fp first", 32'(fp_idx), 32'd0);
    for (int k = 0; k < 6; k++) step("fphold", 32'h0000_0001, 1'b1);
    for (int k = 0; k < 4; k++) step("fpdrop", 32'd0, 1'b1);
    chk("fp drained", 32'(fp_valid), 32'd0);

    // Randomized traffic with sparse requests and random backpressure.
    for (int n = 0; n < 400; n++) begin
      step("rand", $urandom & $urandom & $urandom, ($urandom_range(0, 3) != 0));
    end

    // Reset while an index is presented but not accepted.
    async_reset("reset4");
    step("mid0", 32'h0010_0000, 1'b0);
    step("mid1", 32'd0, 1'b0);
    chk("mid valid", 32'(rr_valid), 32'd1);
    chk("mid idx", 32'(rr_idx), 32'd20);
    #2;
    async_reset("midrst");
    for (int k = 0; k < 3; k++) begin
      step("post", 32'd0, 1'b1);
      chk("post quiet", 32'(rr_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
